fifo_v4: RTL and testbench
==========================

# fifo_v4

Parametrised successor to `fifo_v3`: a single-clock synchronous FIFO with arbitrary (non-power-of-two) depth and configurable data width. It adds an optional fall-through mode, programmable almost-full/almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags. It is a drop-in buffer for streaming datapaths that need back-pressure hints earlier than `full_o`, and diagnostics for protocol misuse.

## Interface
- `DATA_WIDTH`, 32: width of each stored word.
- `DEPTH`, 16: number of entries; any integer ≥ 2.
- `FALL_THROUGH`, 0: 1 = a word pushed into an empty FIFO appears on `data_o` in the same cycle.
- `ALM_FULL_TH`, DEPTH-1: `alm_full_o` asserts when usage ≥ this value; legal range 1..DEPTH.
- `ALM_EMPTY_TH`, 1: `alm_empty_o` asserts when usage ≤ this value; legal range 0..DEPTH-1.
- `CNT_W`, derived as $clog2(DEPTH+1): width of `usage_o`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of contents and error flags.
- `testmode_i`  in  1  test-mode bypass; no functional effect.
- `data_i`  in  DATA_WIDTH  write data.
- `push_i`  in  1  write request.
- `pop_i`  in  1  read request.
- `data_o`  out  DATA_WIDTH  head-of-queue data.
- `full_o`  out  1  usage == DEPTH.
- `empty_o`  out  1  no readable word.
- `alm_full_o`  out  1  usage ≥ ALM_FULL_TH.
- `alm_empty_o`  out  1  usage ≤ ALM_EMPTY_TH.
- `usage_o`  out  CNT_W  number of stored words.
- `overflow_o`  out  1  sticky flag: a push was attempted while full.
- `underflow_o`  out  1  sticky flag: a pop was attempted while empty.

## Operation
- Storage is a DEPTH-entry register array with read and write pointers. Each pointer wraps DEPTH-1 → 0 explicitly; there is no power-of-two masking.
- Priority each cycle is flush > push/pop.
- **Flush:** pointers, usage and both sticky flags clear next edge. push_i and pop_i are ignored in the flush cycle. Memory contents are not cleared.
- **Push accepted** iff push_i && !full_o. The word is written at the write pointer, which then advances.
- **Pop accepted** iff pop_i && !empty_o. The read pointer advances.
- **Simultaneous push and pop:**
  - When full: the pop is accepted and the push is rejected. Usage becomes DEPTH-1 and `overflow_o` sets.
  - When neither full nor empty: both are accepted and usage is unchanged.
- **Usage update:** usage += push_acc − pop_acc.
- **Flags:** `full_o`, `alm_full_o` and `alm_empty_o` are decoded combinationally from the usage register.
- **Normal mode (FALL_THROUGH=0):**
  - `empty_o` = (usage == 0).
  - `data_o` = mem[rd_ptr] at all times; its value is meaningful only while !empty_o.
- **Fall-through mode (FALL_THROUGH=1), when usage == 0 and push_i:**
  - `empty_o` = 0 and `data_o` = `data_i` combinationally.
  - If pop_i is also high, the word is consumed without being stored: pointers and usage are unchanged and `underflow_o` does not set.
  - Otherwise the word is stored normally.
- **Error flags:**
  - `overflow_o` sets on push_i && full_o.
  - `underflow_o` sets on pop_i && empty_o, where `empty_o` is the combinational value including fall-through.
  - Both flags hold until flush or reset.
- `testmode_i` is accepted and ignored.

## Timing
- Reset values while rst_ni = 0:
  - usage_o = 0, empty_o = 1, full_o = 0, alm_empty_o = 1.
  - alm_full_o = 0.
  - overflow_o = 0, underflow_o = 0.
  - data_o = 0: memory resets to zero.
- Reset asserted mid-operation discards all content immediately, without waiting for a clock edge.
- Latency:
  - Normal mode: a word pushed into an empty FIFO at edge N is visible on `data_o` with empty_o = 0 after edge N.
  - Fall-through mode: the word is visible in the same cycle as the push.
- Throughput: one push and one pop per cycle, sustained.
- `full_o` asserts after the edge that accepts the DEPTH-th outstanding push. It deasserts after the first accepted pop.
- No combinational path exists from pop_i to any output. In FALL_THROUGH=1 only, there are combinational paths from push_i/data_i to data_o/empty_o.

## Test plan
- **Fill and drain, DEPTH=5, FT=0.** Push 1..5 → full_o = 1 after the 5th edge and usage_o = 5. Pop 5 times → data_o reads 1,2,3,4,5 in order; then empty_o = 1 and usage_o = 0.
- **Pointer wrap, DEPTH=5.** Continuous push+pop of 1..20 after 3 pre-loaded words → usage_o stays 3 and output order is 1..20 with no loss or duplication.
- **Thresholds, DEPTH=8, ALM_FULL_TH=6, ALM_EMPTY_TH=2.** alm_empty_o drops when usage goes 2→3. alm_full_o rises when usage goes 5→6. full_o = 0 until usage = 8.
- **Errors.** A push of 0xDEAD while full leaves usage 5 and sets overflow_o; contents are unchanged. A pop while empty sets underflow_o. Both flags hold until flush_i = 1, then clear next edge along with usage → 0.
- **Fall-through, FT=1.** Empty FIFO, push 0xA5 with pop_i = 1 → data_o = 0xA5 and empty_o = 0 in the same cycle. Next cycle usage_o = 0 and underflow_o = 0. Push 0xA5 without pop → data_o = 0xA5 in the same cycle and usage_o = 1 next.
- **Asynchronous reset mid-fill.** rst_ni = 0 for 1 ns between edges with 3 words stored → usage_o = 0, empty_o = 1 and data_o = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/fifo_v4.sv
// Single-clock FIFO with arbitrary depth, optional fall-through, almost-full/empty
// thresholds, fill level and sticky overflow/underflow diagnostics.
module fifo_v4 #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned FALL_THROUGH = 0,
    parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
    parameter int unsigned ALM_EMPTY_TH = 1,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  alm_full_o,
    output logic                  alm_empty_o,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] L_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_usage;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_ft_bypass;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_unused;

    assign w_unused = testmode_i;

    assign w_full      = (r_usage == CNT_W'(DEPTH));
    assign w_ft_bypass = (FALL_THROUGH != 0) && (r_usage == '0) && push_i;
    assign w_empty     = (r_usage == '0) && !w_ft_bypass;

    // A bypassed word that is popped in the same cycle is never written to storage.
    assign w_push_acc = !flush_i && push_i && !w_full && !(w_ft_bypass && pop_i);
    assign w_pop_acc  = !flush_i && pop_i && (r_usage != '0);

    assign data_o      = w_ft_bypass ? data_i : r_mem[r_rd_ptr];
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign alm_full_o  = (r_usage >= CNT_W'(ALM_FULL_TH));
    assign alm_empty_o = (r_usage <= CNT_W'(ALM_EMPTY_TH));
    assign usage_o     = r_usage;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

    // NOTE: the storage array is reset too, so data_o reads zero out of reset
    // instead of X; this costs a reset on every flop of the array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_acc) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every process
    // sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_usage     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_usage     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_usage <= r_usage + CNT_W'(1);
                2'b01:   r_usage <= r_usage - CNT_W'(1);
                default: r_usage <= r_usage;
            endcase
            if (push_i && w_full) begin
                r_overflow <= 1'b1;
            end
            if (pop_i && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_v4.sv
// Directed bench for fifo_v4: three instances cover normal mode at DEPTH=5,
// custom thresholds at DEPTH=8, and fall-through mode.
`timescale 1ns/100ps
module tb_fifo_v4;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: DEPTH=5, normal mode, default thresholds (4 / 1)
    logic          a_flush, a_push, a_pop;
    logic [DW-1:0] a_data, a_dout;
    logic          a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
    logic [2:0]    a_usage;

    fifo_v4 #(.DATA_WIDTH(DW), .DEPTH(5), .FALL_THROUGH(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(1'b0),
        .data_i(a_data), .push_i(a_push), .pop_i(a_pop), .data_o(a_dout),
        .full_o(a_full), .empty_o(a_empty), .alm_full_o(a_afull),
        .alm_empty_o(a_aempty), .usage_o(a_usage), .overflow_o(a_ovf),
        .underflow_o(a_unf)
    );

    // Instance B: DEPTH=8, ALM_FULL_TH=6, ALM_EMPTY_TH=2
    logic          b_push;
    logic [DW-1:0] b_data, b_dout;
    logic          b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
    logic [3:0]    b_usage;

    fifo_v4 #(.DATA_WIDTH(DW), .DEPTH(8), .FALL_THROUGH(0),
              .ALM_FULL_TH(6), .ALM_EMPTY_TH(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .testmode_i(1'b1),
        .data_i(b_data), .push_i(b_push), .pop_i(1'b0), .data_o(b_dout),
        .full_o(b_full), .empty_o(b_empty), .alm_full_o(b_afull),
        .alm_empty_o(b_aempty), .usage_o(b_usage), .overflow_o(b_ovf),
        .underflow_o(b_unf)
    );

    // Instance C: DEPTH=4, fall-through mode
    logic          c_push, c_pop;
    logic [DW-1:0] c_data, c_dout;
    logic          c_full, c_empty, c_afull, c_aempty, c_ovf, c_unf;
    logic [2:0]    c_usage;

    fifo_v4 #(.DATA_WIDTH(DW), .DEPTH(4), .FALL_THROUGH(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .testmode_i(1'b0),
        .data_i(c_data), .push_i(c_push), .pop_i(c_pop), .data_o(c_dout),
        .full_o(c_full), .empty_o(c_empty), .alm_full_o(c_afull),
        .alm_empty_o(c_aempty), .usage_o(c_usage), .overflow_o(c_ovf),
        .underflow_o(c_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_data = '0;
        b_push  = 1'b0; b_data = '0;
        c_push  = 1'b0; c_pop  = 1'b0; c_data = '0;

        // Reset values
        #2;
        check("rst_usage",     32'(a_usage),  32'd0);
        check("rst_empty",     32'(a_empty),  32'd1);
        check("rst_full",      32'(a_full),   32'd0);
        check("rst_alm_empty", 32'(a_aempty), 32'd1);
        check("rst_alm_full",  32'(a_afull),  32'd0);
        check("rst_overflow",  32'(a_ovf),    32'd0);
        check("rst_underflow", 32'(a_unf),    32'd0);
        check("rst_data",      32'(a_dout),   32'd0);
        #10;
        rst_n = 1'b1;
        cyc();

        // Fill A with 1..5; normal mode shows nothing until the edge
        for (int i = 1; i <= 5; i++) begin
            a_push = 1'b1;
            a_data = DW'(i);
            if (i == 1) begin
                #1;
                check("a_nofallthru_empty", 32'(a_empty), 32'd1);
            end
            cyc();
            if (i == 1) begin
                check("a_first_data",  32'(a_dout),  32'd1);
                check("a_first_empty", 32'(a_empty), 32'd0);
            end
            if (i == 4) begin
                check("a_full_at4", 32'(a_full), 32'd0);
            end
        end
        a_push = 1'b0;
        check("a_full",  32'(a_full),  32'd1);
        check("a_usage5", 32'(a_usage), 32'd5);

        // Overflow: push while full
        a_push = 1'b1;
        a_data = 16'hDEAD;
        cyc();
        a_push = 1'b0;
        check("ovf_usage", 32'(a_usage), 32'd5);
        check("ovf_flag",  32'(a_ovf),   32'd1);
        check("ovf_head",  32'(a_dout),  32'd1);

        // Drain in order
        for (int i = 1; i <= 5; i++) begin
            check("drain_data", 32'(a_dout), 32'(i));
            a_pop = 1'b1;
            cyc();
            if (i == 1) begin
                check("drain_full_drop", 32'(a_full), 32'd0);
            end
        end
        a_pop = 1'b0;
        check("drain_empty", 32'(a_empty), 32'd1);
        check("drain_usage", 32'(a_usage), 32'd0);
        check("ovf_sticky",  32'(a_ovf),   32'd1);

        // Underflow: pop while empty
        a_pop = 1'b1;
        cyc();
        a_pop = 1'b0;
        check("unf_flag",  32'(a_unf),   32'd1);
        check("unf_usage", 32'(a_usage), 32'd0);

        // Store two words, then flush with push/pop also requested
        a_push = 1'b1; a_data = 16'h0007; cyc();
        a_data = 16'h0008; cyc();
        check("pre_flush_usage", 32'(a_usage), 32'd2);
        check("unf_sticky",      32'(a_unf),   32'd1);
        a_flush = 1'b1; a_pop = 1'b1; a_data = 16'h0009;
        cyc();
        a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0;
        check("flush_usage", 32'(a_usage), 32'd0);
        check("flush_empty", 32'(a_empty), 32'd1);
        check("flush_ovf",   32'(a_ovf),   32'd0);
        check("flush_unf",   32'(a_unf),   32'd0);

        // Pointer wrap: preload 1..3, then 20 cycles of push+pop
        for (int i = 1; i <= 3; i++) begin
            a_push = 1'b1; a_data = DW'(i); cyc();
        end
        for (int i = 0; i < 20; i++) begin
            a_push = 1'b1; a_pop = 1'b1; a_data = DW'(i + 4);
            check("wrap_data", 32'(a_dout), 32'(i + 1));
            cyc();
            check("wrap_usage", 32'(a_usage), 32'd3);
        end
        a_push = 1'b0;
        for (int i = 21; i <= 23; i++) begin
            check("wrap_tail", 32'(a_dout), 32'(i));
            cyc();
        end
        a_pop = 1'b0;
        check("wrap_empty", 32'(a_empty), 32'd1);
        check("wrap_unf",   32'(a_unf),   32'd0);

        // Thresholds on B
        check("th_aempty0", 32'(b_aempty), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            b_push = 1'b1; b_data = DW'(k);
            cyc();
            check("th_usage",  32'(b_usage),  32'(k));
            check("th_aempty", 32'(b_aempty), (k <= 2) ? 32'd1 : 32'd0);
            check("th_afull",  32'(b_afull),  (k >= 6) ? 32'd1 : 32'd0);
            check("th_full",   32'(b_full),   (k == 8) ? 32'd1 : 32'd0);
        end
        b_push = 1'b0;

        // Fall-through on C: push+pop into empty bypasses storage
        c_push = 1'b1; c_pop = 1'b1; c_data = 16'h00A5;
        #1;
        check("ft_pp_data",  32'(c_dout),  32'h00A5);
        check("ft_pp_empty", 32'(c_empty), 32'd0);
        cyc();
        c_push = 1'b0; c_pop = 1'b0;
        #1;
        check("ft_pp_usage", 32'(c_usage), 32'd0);
        check("ft_pp_unf",   32'(c_unf),   32'd0);
        check("ft_idle_empty", 32'(c_empty), 32'd1);

        // Push only: visible now, stored after the edge
        c_push = 1'b1; c_data = 16'h00A5;
        #1;
        check("ft_p_data",  32'(c_dout),  32'h00A5);
        check("ft_p_empty", 32'(c_empty), 32'd0);
        cyc();
        c_data = 16'h0011; cyc();
        c_data = 16'h0022; cyc();
        c_push = 1'b0;
        check("ft_usage3", 32'(c_usage), 32'd3);
        check("ft_head",   32'(c_dout),  32'h00A5);

        // Asynchronous reset between edges with 3 words stored
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_usage", 32'(c_usage), 32'd0);
        check("arst_empty", 32'(c_empty), 32'd1);
        check("arst_data",  32'(c_dout),  32'd0);
        check("arst_b_usage", 32'(b_usage), 32'd0);
        rst_n = 1'b1;
        #1;
        check("arst_hold_usage", 32'(c_usage), 32'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
